// File: rtl/reg_snapshot_if.sv
// Register-snapshot bus: scan request/status, register-file read port,
// PC input and the VGA-side display read port.
interface reg_snapshot_if;
  logic        start;
  logic [15:0] rdData;
  logic [15:0] pcData;
  logic [2:0]  dispSel;
  logic [5:0]  rdAddr;
  logic        busy;
  logic        done;
  logic [15:0] dispData;
  logic [7:0]  scanCount;

  // master: requester / register file / VGA side
  modport master (
    output start, rdData, pcData, dispSel,
    input  rdAddr, busy, done, dispData, scanCount
  );

  // slave: the snapshot block itself
  modport slave (
    input  start, rdData, pcData, dispSel,
    output rdAddr, busy, done, dispData, scanCount
  );
endinterface

// File: rtl/reg_snapshot.sv
// reg_snapshot: scans NREGS register-file entries into a shadow copy, one per
// cycle, then publishes the whole shadow to a display buffer in one edge so
// the VGA reader never sees a half-updated snapshot.
// Optional feature macro SNAP_PC_EN: adds a PCCAP state that captures pcData
// as shadow/display entry NREGS.
module reg_snapshot #(
  parameter int NREGS = 6
) (
  input logic           clk,
  input logic           rst,
  reg_snapshot_if.slave bus
);

`ifdef SNAP_PC_EN
  localparam int NENT = NREGS + 1;
  typedef enum logic [1:0] {IDLE, SCAN, PCCAP, COMMIT} state_t;
`else
  localparam int NENT = NREGS;
  typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;
`endif

  localparam logic [2:0] LAST = 3'(NREGS - 1);

  state_t      state, nextState;
  logic [2:0]  addr, addrNxt;
  logic        busyQ, busyNxt;
  logic        doneQ, doneNxt;
  logic [7:0]  count;
  logic [15:0] shadow [NENT];
  logic [15:0] disp   [NENT];

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  // next-state logic; start only matters in IDLE, so requests during a scan
  // or the commit cycle are dropped rather than queued
  always_comb begin
    nextState = state;
    case (state)
      IDLE:   if (bus.start) nextState = SCAN;
`ifdef SNAP_PC_EN
      SCAN:   if (addr == LAST) nextState = PCCAP;
      PCCAP:  nextState = COMMIT;
`else
      SCAN:   if (addr == LAST) nextState = COMMIT;
`endif
      COMMIT: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // output logic: next values of the registered outputs, derived from the
  // state being entered so busy/done line up with that state
  always_comb begin
    busyNxt = (nextState != IDLE);
    doneNxt = (nextState == COMMIT);
    addrNxt = 3'd0;
    if (state == SCAN && addr != LAST) addrNxt = addr + 3'd1;
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= 3'd0;
      busyQ <= 1'b0;
      doneQ <= 1'b0;
    end else begin
      addr  <= addrNxt;
      busyQ <= busyNxt;
      doneQ <= doneNxt;
    end
  end

  // shadow capture: one register entry per SCAN cycle, PC after the last one
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) shadow[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        if (state == SCAN && addr == 3'(i)) shadow[i] <= bus.rdData;
`ifdef SNAP_PC_EN
      if (state == PCCAP) shadow[NREGS] <= bus.pcData;
`endif
    end
  end

  // atomic publish of the whole shadow plus commit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NENT; i++) disp[i] <= '0;
      count <= 8'd0;
    end else if (state == COMMIT) begin
      for (int i = 0; i < NENT; i++) disp[i] <= shadow[i];
      count <= count + 8'd1;
    end
  end

  // display read port; selectors past the captured entries read as zero
  always_comb begin
    bus.dispData = 16'h0000;
    for (int i = 0; i < NENT; i++)
      if (bus.dispSel == 3'(i)) bus.dispData = disp[i];
  end

`ifndef SNAP_PC_EN
  // pcData has no consumer in this build
  logic unusedPc;
  assign unusedPc = ^bus.pcData;
`endif

  assign bus.rdAddr    = {3'b000, addr};
  assign bus.busy      = busyQ;
  assign bus.done      = doneQ;
  assign bus.scanCount = count;

endmodule

// File: tb/tb_reg_snapshot.sv
// Bench for reg_snapshot: scoreboard model of scan/commit behaviour checked
// every cycle, plus directed scenarios with literal expectations.
module tb_reg_snapshot;
  localparam int NREGS = 6;
`ifdef SNAP_PC_EN
  localparam int NENT   = 7;
  localparam int LAT    = 7;
  localparam int PERIOD = 9;
  localparam logic [15:0] PC_EXP = 16'h1234;
`else
  localparam int NENT   = 6;
  localparam int LAT    = 6;
  localparam int PERIOD = 8;
  localparam logic [15:0] PC_EXP = 16'h0000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] regs [6];

  reg_snapshot_if bus();

  reg_snapshot #(.NREGS(NREGS)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  assign bus.rdData = (bus.rdAddr < 6'd6) ? regs[bus.rdAddr[2:0]] : 16'h0000;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A scan accepted at an edge walks phases 0..NENT: phases < NREGS read
  // register p, phase NREGS (PC build) reads pcData, phase NENT is commit.
  bit          mActive = 1'b0;
  int          mPhase  = 0;
  logic [7:0]  mCount  = 8'd0;
  logic [15:0] mCap  [8];
  logic [15:0] mDisp [8];

  always @(posedge clk) begin
    if (rst) begin
      mActive <= 1'b0;
      mPhase  <= 0;
      mCount  <= 8'd0;
      for (int i = 0; i < 8; i++) begin
        mCap[i]  <= 16'h0;
        mDisp[i] <= 16'h0;
      end
    end else if (!mActive) begin
      if (bus.start) begin
        mActive <= 1'b1;
        mPhase  <= 0;
      end
    end else begin
      if (mPhase < NREGS)     mCap[mPhase] <= regs[mPhase];
      else if (mPhase < NENT) mCap[mPhase] <= bus.pcData;
      if (mPhase == NENT) begin
        for (int i = 0; i < 8; i++) mDisp[i] <= mCap[i];
        mCount  <= mCount + 8'd1;
        mActive <= 1'b0;
        mPhase  <= 0;
      end else begin
        mPhase <= mPhase + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cmpEn = 1'b0;
  bit prevDone = 1'b0;
  int doneCnt = 0;
  int cyc = 0;
  int lastDone = 0;
  int lastGap = 0;

  always @(negedge clk) begin
    cyc++;
    if (cmpEn) begin
      logic [15:0] expDisp;
      logic [5:0]  expAddr;
      expDisp = (int'(bus.dispSel) < NENT) ? mDisp[bus.dispSel] : 16'h0;
      expAddr = (mActive && mPhase < NREGS) ? 6'(mPhase) : 6'd0;
      check("busy", {31'd0, bus.busy}, {31'd0, mActive});
      check("done", {31'd0, bus.done}, {31'd0, (mActive && mPhase == NENT)});
      check("rdAddr", {26'd0, bus.rdAddr}, {26'd0, expAddr});
      check("scanCount", {24'd0, bus.scanCount}, {24'd0, mCount});
      check("dispData", {16'd0, bus.dispData}, {16'd0, expDisp});
      if (bus.done) begin
        check("doneGap", {31'd0, prevDone}, 32'd0);
        doneCnt++;
        lastGap  = cyc - lastDone;
        lastDone = cyc;
      end
    end
    prevDone = bus.done;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulseStart();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic waitIdle();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      if (!bus.busy) seen = 1'b1;
    end
    if (!seen) check("idleTimeout", 32'd0, 32'd1);
    tick();
  endtask

  task automatic waitAddr3();
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (bus.rdAddr == 6'd3) seen = 1'b1;
    end
    if (!seen) check("addr3Timeout", 32'd0, 32'd1);
  endtask

  task automatic checkDisp(input string name, input logic [2:0] sel, input logic [15:0] exp);
    bus.dispSel = sel;
    #1;
    check(name, {16'd0, bus.dispData}, {16'd0, exp});
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int lat;
    int d0;
    bit got;
    bus.start   = 1'b0;
    bus.dispSel = 3'd0;
    bus.pcData  = 16'h1234;
    for (int i = 0; i < 6; i++) regs[i] = 16'((i + 1) * 16'h0011);

    // reset
    rst = 1'b1;
    tick();
    tick();
    cmpEn = 1'b1;
    rst = 1'b0;
    check("rstBusy", {31'd0, bus.busy}, 32'd0);
    check("rstDone", {31'd0, bus.done}, 32'd0);
    check("rstCount", {24'd0, bus.scanCount}, 32'd0);
    check("rstAddr", {26'd0, bus.rdAddr}, 32'd0);
    tick();

    // single scan, latency, captured values
    pulseStart();
    lat = 0;
    got = 1'b0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.done) got = 1'b1;
    end
    check("latency", lat, LAT);
    tick();
    waitIdle();
    checkDisp("disp3", 3'd3, 16'h0044);
    checkDisp("disp0", 3'd0, 16'h0011);
    checkDisp("disp5", 3'd5, 16'h0066);
    checkDisp("disp6", 3'd6, PC_EXP);
    checkDisp("disp7", 3'd7, 16'h0000);
    check("count1", {24'd0, bus.scanCount}, 32'd1);
    check("done1", doneCnt, 1);

    // register change after address 2 was read
    bus.dispSel = 3'd2;
    pulseStart();
    waitAddr3();
    tick();
    regs[2] = 16'hBEEF;
    waitIdle();
    checkDisp("midScanOld", 3'd2, 16'h0033);
    pulseStart();
    waitIdle();
    checkDisp("midScanNew", 3'd2, 16'hBEEF);
    regs[2] = 16'h0033;

    // start held high for 20 cycles
    d0 = doneCnt;
    bus.start = 1'b1;
    repeat (20) tick();
    bus.start = 1'b0;
    waitIdle();
    check("holdCommits", doneCnt - d0, 3);
    check("holdPeriod", lastGap, PERIOD);
    check("countHold", {24'd0, bus.scanCount}, 32'd6);

    // reset in the middle of a scan
    pulseStart();
    waitAddr3();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    d0 = doneCnt;
    @(negedge clk);
    check("abortBusy", {31'd0, bus.busy}, 32'd0);
    check("abortCount", {24'd0, bus.scanCount}, 32'd0);
    tick();
    for (int s = 0; s < 8; s++) checkDisp("abortDisp", 3'(s), 16'h0000);
    repeat (12) tick();
    check("abortNoDone", doneCnt - d0, 0);

    // 256 scans: counter wraps
    for (int k = 0; k < 255; k++) begin
      pulseStart();
      waitIdle();
    end
    check("count255", {24'd0, bus.scanCount}, 32'd255);
    pulseStart();
    waitIdle();
    check("countWrap", {24'd0, bus.scanCount}, 32'd0);
    checkDisp("wrapDisp6", 3'd6, PC_EXP);
    checkDisp("wrapDisp7", 3'd7, 16'h0000);

    cmpEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_snapshot.md
REG_SNAPSHOT -- requirements
Module: reg_snapshot

Interface
REQ-001 The block SHALL have parameter NREGS, default 6, giving the number of register-file entries scanned (legal 1..6, addresses 0..NREGS-1).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, the scan request, sampled only in IDLE.
REQ-005 The block SHALL have port rdData, input, 16, the register-file read data for rdAddr, combinational from rdAddr.
REQ-006 The block SHALL have port pcData, input, 16, the current PC value; it is used only when SNAP_PC_EN is defined.
REQ-007 The block SHALL have port dispSel, input, 3, the display-buffer entry selector from the VGA side.
REQ-008 The block SHALL have port rdAddr, output, 6, the register-file read address driven during the scan.
REQ-009 The block SHALL have port busy, output, 1, high while a scan or commit is in progress.
REQ-010 The block SHALL have port done, output, 1, a one-cycle pulse on commit.
REQ-011 The block SHALL have port dispData, output, 16, the display-buffer entry selected by dispSel, combinational.
REQ-012 The block SHALL have port scanCount, output, 8, the number of completed commits, modulo 256.

Function
REQ-013 The FSM SHALL have states IDLE, SCAN, PCCAP (SNAP_PC_EN only) and COMMIT; all outputs SHALL be registered except dispData.
REQ-014 In IDLE with start=1 at an edge, the FSM SHALL go to SCAN with rdAddr=0; with start=0 it SHALL stay in IDLE with rdAddr held at 0.
REQ-015 In SCAN, each edge SHALL write shadow[rdAddr] with rdData, giving one entry per cycle.
REQ-016 If rdAddr<NREGS-1 the scan SHALL increment rdAddr; otherwise rdAddr SHALL return to 0 and the FSM SHALL go to PCCAP if SNAP_PC_EN is defined, else to COMMIT.
REQ-017 COMMIT SHALL copy all shadow entries to the display buffer at a single edge (atomic), increment scanCount (255 wraps to 0), and return to IDLE.
REQ-018 done SHALL be high exactly during the COMMIT cycle; busy SHALL be high in SCAN, PCCAP and COMMIT, and low in IDLE.
REQ-019 Latency: with start sampled at edge E0, done SHALL be high in the cycle after edge E0+NREGS, or E0+NREGS+1 when SNAP_PC_EN is defined.
REQ-020 start while busy=1 SHALL be ignored, with no queuing; start high during the COMMIT cycle SHALL NOT be accepted.
REQ-021 A new scan SHALL be accepted at the first edge the FSM is in IDLE, so back-to-back scans are separated by at least one IDLE cycle.
REQ-022 The display buffer SHALL change only at COMMIT; dispData SHALL never show a partially updated snapshot.
REQ-023 dispSel values at or beyond the number of captured entries SHALL return dispData=0.
REQ-024 rdAddr SHALL never exceed NREGS-1.

Reset
REQ-025 With rst=1 at an edge, state SHALL be IDLE and rdAddr=0, busy=0, done=0, scanCount=0, with all shadow and display entries 0.
REQ-026 rst SHALL take priority over start and over any in-progress scan; a scan aborted by reset SHALL produce no done and no commit.
REQ-027 After rst deasserts, the first edge with start=1 SHALL begin a scan.

Configuration
REQ-028 With macro SNAP_PC_EN defined, PCCAP SHALL capture pcData into shadow entry NREGS for one cycle and commit it with the rest; dispSel=NREGS SHALL return it.
REQ-029 Without SNAP_PC_EN, the PCCAP state, pcData use and entry NREGS SHALL be absent, pcData SHALL be ignored, and dispSel=NREGS SHALL return 0.

Verification
REQ-030 Model regs 0..5 = 0x0011..0x0066 and pulse start for one cycle -> rdAddr steps 0..5, done pulses once 6 cycles later (7 with SNAP_PC_EN), dispData for dispSel=3 is 0x0044, scanCount=1.
REQ-031 Hold start high for 20 cycles -> commits occur every 8 cycles (9 with SNAP_PC_EN), done is never high on consecutive cycles, and starts during busy are ignored.
REQ-032 Change reg2 from 0x0033 to 0xBEEF during the scan after address 2 has been read -> the display shows 0x0033 until the next commit, with no mid-scan change to dispData.
REQ-033 Assert rst at rdAddr=3 -> next cycle busy=0, done never pulses, dispData=0 for all dispSel, scanCount=0.
REQ-034 Run 256 scans -> scanCount wraps 255 to 0.
REQ-035 With SNAP_PC_EN defined and pcData=0x1234, scan then dispSel=6 -> dispData=0x1234; without the macro, dispSel=6 and dispSel=7 -> dispData=0.
